mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle main control FSM for the MIPS datapath. Decodes the instruction register
//  opcode, steps fetch/decode/execute/memory/writeback, and drives all datapath enables.
//  Generates EXTOp for the immediate extender, memory handshake strobes and a retire count.
// PARAMETERS
//  CNT_WIDTH    32  width of retired_count
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready before bus error (>=1)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous, active-high reset
//  opcode        in   6   IR[31:26]
//  mem_ready     in   1   memory completed current read/write this cycle
//  PCWrite       out  1   unconditional PC load
//  PCWriteCond   out  1   PC load if ALU zero (beq)
//  IorD          out  1   0=PC addresses memory, 1=ALUOut
//  MemRead       out  1   memory read strobe, held until mem_ready
//  MemWrite      out  1   memory write strobe, held until mem_ready
//  IRWrite       out  1   latch IR
//  RegWrite      out  1   register file write
//  RegDst        out  1   0=rt, 1=rd
//  MemtoReg      out  1   0=ALUOut, 1=MDR
//  ALUSrcA       out  1   0=PC, 1=A
//  ALUSrcB       out  2   00=B, 01=4, 10=ext imm, 11=ext imm<<2
//  ALUOp         out  2   00=add, 01=sub, 10=funct, 11=or
//  PCSource      out  2   00=ALU, 01=ALUOut, 10=jump target
//  EXTOp         out  2   `EXTOP_* code for extender
//  illegal_op    out  1   1-cycle pulse, unknown opcode in DECODE
//  bus_err       out  1   1-cycle pulse, memory timeout
//  retired_count out  CNT_WIDTH  completed instructions, wraps
//  state         out  4   current state (debug)
// BEHAVIOUR
//  Reset: state=FETCH(0), retired_count=0, wait counter=0, pulses 0. Outputs are Moore
//   decodes of state, so FETCH's decode applies during reset.
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC_R6 ALUWB7 BRANCH8 JUMP9 EXEC_I10.
//  Default outputs are 0 unless listed. EXTOp defaults to `EXTOP_SIGNED.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
//   On mem_ready: IRWrite=1, PCWrite=1, PCSource=00, next DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, EXTOp=SIGNED (branch target). Dispatch on opcode:
//   000000->EXEC_R; 100011 lw / 101011 sw->MEMADR; 000100 beq->BRANCH;
//   000010 j->JUMP; 001000 addi, 001001 addiu, 001101 ori, 001111 lui->EXEC_I;
//   any other opcode->FETCH with illegal_op=1. An illegal op does not retire.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, EXTOp=SIGNED; lw->MEMRD, sw->MEMWR.
//  MEMRD: MemRead=1, IorD=1; on mem_ready->MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
//  MEMWR: MemWrite=1, IorD=1; on mem_ready->FETCH (retires).
//  EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB, which sets RegDst=1.
//  EXEC_I: ALUSrcA=1, ALUSrcB=10. addi/addiu: ALUOp=00, EXTOp=SIGNED.
//   ori: ALUOp=11, EXTOp=UNSIGNED. lui: ALUOp=11, EXTOp=UNSIGNED. Next ALUWB with RegDst=0.
//  ALUWB: RegWrite=1, MemtoReg=0 -> FETCH (retires).
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH (retires).
//  JUMP: PCWrite=1, PCSource=10, EXTOp=`EXTOP_INST -> FETCH (retires).
//  Opcode is sampled in DECODE and in every later state. The IR is stable after FETCH.
//  Memory wait:
//   - A counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle
//     mem_ready=0 in those states.
//   - When the count reaches MEM_TIMEOUT-1 with mem_ready still 0: bus_err=1 for one
//     cycle, next FETCH, no retire. In FETCH a timeout re-enters FETCH and the counter clears.
//   - mem_ready outside those 3 states is ignored.
//  Retire:
//   - retired_count increments on the clock edge that leaves MEMWB, ALUWB, MEMWR (on ready),
//     BRANCH or JUMP.
//   - Wraps from all-ones to 0 modulo 2^CNT_WIDTH.
//  rst mid-instruction: immediate return to FETCH, count cleared, no partial write strobes.
//  Latency with mem_ready tied 1: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3.
// TESTING
//  1. rst=1 then release, mem_ready=1, opcode=000000 -> states 0,1,6,7,0;
//     RegWrite=1 only in 7; retired_count=1.
//  2. opcode=001101 (ori) -> EXEC_I has EXTOp=UNSIGNED, ALUOp=11; DECODE has EXTOp=SIGNED.
//  3. lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1, IorD=1;
//     then MEMWB with MemtoReg=1; count+1.
//  4. sw with mem_ready=0 forever, MEM_TIMEOUT=16 -> bus_err pulses after 16 MEMWR cycles;
//     FETCH follows; count unchanged.
//  5. opcode=111111 -> illegal_op pulse in DECODE, back to FETCH, no retire.
//     j -> PCSource=10 and EXTOp=INST in JUMP.
//  6. Assert rst during MEMWR -> MemWrite drops immediately, state=0, count=0.
//     Preload count to all-ones (CNT_WIDTH=4, 15 beq) then one more -> count wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: opcode/handshake inputs and datapath control outputs of the multicycle control FSM
interface mc_control_fsm_if #(parameter int CNT_WIDTH = 32);
  logic [5:0] opcode;
  logic mem_ready;
  logic PCWrite;
  logic PCWriteCond;
  logic IorD;
  logic MemRead;
  logic MemWrite;
  logic IRWrite;
  logic RegWrite;
  logic RegDst;
  logic MemtoReg;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [1:0] EXTOp;
  logic illegal_op;
  logic bus_err;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [3:0] state;
  modport master (
    input opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, illegal_op, bus_err, retired_count, state
  );
  modport slave (
    output opcode, mem_ready,
    input PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
    input ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, illegal_op, bus_err, retired_count, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control with memory wait timeout and retire counter
module mc_control_fsm #(
  parameter int CNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  mc_control_fsm_if.master bus
);
  localparam logic [1:0] EXTOP_SIGNED = 2'b00;
  localparam logic [1:0] EXTOP_UNSIGNED = 2'b01;
  localparam logic [1:0] EXTOP_INST = 2'b10;
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, BRANCH, JUMP, EXEC_I
  } state_t;
  state_t st, nst;
  logic [CW-1:0] cnt;
  logic [CNT_WIDTH-1:0] retired;
  logic r_type, lw, sw, beq, jmp, i_type, logic_imm, waiting, timeout, retire;
  assign r_type = bus.opcode == 6'b000000;
  assign lw = bus.opcode == 6'b100011;
  assign sw = bus.opcode == 6'b101011;
  assign beq = bus.opcode == 6'b000100;
  assign jmp = bus.opcode == 6'b000010;
  assign logic_imm = bus.opcode == 6'b001101 || bus.opcode == 6'b001111;
  assign i_type = logic_imm || bus.opcode == 6'b001000 || bus.opcode == 6'b001001;
  // the wait counter self-clears whenever a wait state is left or times out, so entry always sees 0
  assign waiting = st == FETCH || st == MEMRD || st == MEMWR;
  assign timeout = waiting && !bus.mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
  assign retire = st == MEMWB || st == ALUWB || st == BRANCH || st == JUMP || (st == MEMWR && bus.mem_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= FETCH;
    else st <= nst;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      retired <= '0;
    end else begin
      cnt <= (waiting && !bus.mem_ready && !timeout) ? cnt + CW'(1) : '0;
      retired <= retired + CNT_WIDTH'(retire);
    end
  always_comb begin
    nst = FETCH;
    case (st)
      FETCH: nst = bus.mem_ready ? DECODE : FETCH;
      DECODE: nst = r_type ? EXEC_R : (lw || sw) ? MEMADR : beq ? BRANCH : jmp ? JUMP : i_type ? EXEC_I : FETCH;
      MEMADR: nst = lw ? MEMRD : MEMWR;
      MEMRD: nst = bus.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
      MEMWR: nst = (bus.mem_ready || timeout) ? FETCH : MEMWR;
      EXEC_R, EXEC_I: nst = ALUWB;
      default: nst = FETCH;
    endcase
  end
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00;
    bus.ALUOp = 2'b00;
    bus.PCSource = 2'b00;
    bus.EXTOp = EXTOP_SIGNED;
    case (st)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: bus.ALUSrcB = 2'b11;
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD = 1'b1;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp = 2'b10;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst = r_type;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource = 2'b01;
      end
      JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSource = 2'b10;
        bus.EXTOp = EXTOP_INST;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp = logic_imm ? 2'b11 : 2'b00;
        bus.EXTOp = logic_imm ? EXTOP_UNSIGNED : EXTOP_SIGNED;
      end
      default: ;
    endcase
  end
  assign bus.illegal_op = st == DECODE && !(r_type || lw || sw || beq || jmp || i_type);
  assign bus.bus_err = timeout;
  assign bus.retired_count = retired;
  assign bus.state = st;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: builds per-instruction expected state traces from opcode and memory delays, checks every cycle
module tb_mc_control_fsm;
  localparam int CW = 4;
  localparam int MT = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mc_control_fsm_if #(.CNT_WIDTH(CW)) bus ();
  mc_control_fsm #(.CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [3:0] st; logic rdy; logic to; logic ret;} step_t;
  step_t trace[$];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;
  logic [5:0] cur_op;
  logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h09, 6'h0d, 6'h0f};
  logic [19:0] obs_out;
  assign obs_out = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                    bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.PCSource, bus.EXTOp, bus.illegal_op, bus.bus_err};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h09, 6'h0d, 6'h0f};
  endfunction
  // expected control word per state, straight from the state descriptions
  function automatic logic [19:0] exp_out(input step_t s, input logic [5:0] op);
    logic pcw, pcc, iord, mrd, mwr, irw, rw, rd, m2r, asa, ill, imm_log;
    logic [1:0] asb, aop, pcs, ext;
    {pcw, pcc, iord, mrd, mwr, irw, rw, rd, m2r, asa, ill} = '0;
    {asb, aop, pcs, ext} = '0;
    imm_log = op == 6'h0d || op == 6'h0f;
    case (s.st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = s.rdy; pcw = s.rdy; end
      4'd1: begin asb = 2'b11; ill = !legal(op); end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = op == 6'h00; end
      4'd8: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; ext = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; aop = imm_log ? 2'b11 : 2'b00; ext = imm_log ? 2'b01 : 2'b00; end
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, rw, rd, m2r, asa, asb, aop, pcs, ext, ill, s.to};
  endfunction
  task automatic push(input logic [3:0] st);
    trace.push_back('{st, 1'($urandom), 1'b0, 1'b0});
  endtask
  // d not-ready cycles then ready; d >= MT means MT not-ready cycles ending in a bus error
  task automatic add_wait(input logic [3:0] st, input int d, output bit to);
    to = d >= MT;
    for (int i = 0; i < (to ? MT : d); i++) trace.push_back('{st, 1'b0, to && i == MT - 1, 1'b0});
    if (!to) trace.push_back('{st, 1'b1, 1'b0, 1'b0});
  endtask
  task automatic build(input logic [5:0] op, input int df, input int dm);
    bit to;
    trace.delete();
    add_wait(4'd0, df, to);
    if (to) return;
    push(4'd1);
    if (!legal(op)) return;
    case (op)
      6'h00: begin push(4'd6); push(4'd7); end
      6'h23: begin push(4'd2); add_wait(4'd3, dm, to); if (!to) push(4'd4); end
      6'h2b: begin push(4'd2); add_wait(4'd5, dm, to); end
      6'h04: push(4'd8);
      6'h02: push(4'd9);
      default: begin push(4'd10); push(4'd7); end
    endcase
    if (!to) trace[trace.size() - 1].ret = 1'b1;
  endtask
  task automatic play(input int n);
    for (int i = 0; i < n && i < trace.size(); i++) begin
      bus.opcode = cur_op;
      bus.mem_ready = trace[i].rdy;
      #1;
      chk("state", 32'(bus.state), 32'(trace[i].st));
      chk("outputs", 32'(obs_out), 32'(exp_out(trace[i], cur_op)));
      chk("retired", 32'(bus.retired_count), 32'(exp_cnt));
      if (trace[i].ret) exp_cnt++;
      @(negedge clk);
    end
  endtask
  task automatic instr(input logic [5:0] op, input int df, input int dm);
    cur_op = op;
    build(op, df, dm);
    play(trace.size());
  endtask
  initial begin
    rst = 1'b1;
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_outputs", 32'(obs_out), 32'(exp_out('{4'd0, 1'b0, 1'b0, 1'b0}, 6'h00)));
    chk("reset_count", 32'(bus.retired_count), 0);
    @(negedge clk);
    rst = 1'b0;
    instr(6'h00, 0, 0);
    instr(6'h0d, 0, 0);
    instr(6'h0f, 0, 0);
    instr(6'h08, 0, 0);
    instr(6'h23, 0, 3);
    instr(6'h2b, 0, 100);
    instr(6'h23, 100, 0);
    instr(6'h3f, 0, 0);
    instr(6'h02, 0, 0);
    instr(6'h04, 1, 0);
    instr(6'h2b, 2, 1);
    cur_op = 6'h2b;
    build(6'h2b, 0, 100);
    play(4);
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr_before_rst", 32'(bus.MemWrite), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_memwrite", 32'(bus.MemWrite), 0);
    chk("rst_count", 32'(bus.retired_count), 0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) instr(6'h04, 0, 0);
    chk("count_all_ones", 32'(bus.retired_count), 32'hF);
    instr(6'h04, 0, 0);
    chk("count_wrap", 32'(bus.retired_count), 0);
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      int df, dm;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      df = ($urandom_range(0, 9) == 0) ? MT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      dm = ($urandom_range(0, 7) == 0) ? MT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      instr(op, df, dm);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
